// File: rtl/alu_exec_unit.sv
// alu_exec_unit: 16-bit execute stage, one ALU op per clock, registered writeback.
// Define ALU_MUL_EN to build the multi-cycle shift-add unsigned multiplier (opcode 11).
module alu_exec_unit #(
    parameter int WIDTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [AW-1:0]    rd,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             wb_write,
    output logic [AW-1:0]    wb_ra,
    output logic [WIDTH-1:0] wb_data,
    output logic [3:0]       flags
);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;
    localparam logic [3:0] OP_SRA = 4'd8;
    localparam logic [3:0] OP_MOV = 4'd9;
    localparam logic [3:0] OP_SLT = 4'd10;
`ifdef ALU_MUL_EN
    localparam logic [3:0] OP_MUL = 4'd11;
`endif

    localparam int MSB = WIDTH - 1;

    logic                    r_wb_write;
    logic [AW-1:0]           r_wb_ra;
    logic [WIDTH-1:0]        r_wb_data;
    logic [3:0]              r_flags;

    logic [3:0]              w_sh;
    logic [WIDTH:0]          w_sum;
    logic [WIDTH:0]          w_diff;
    logic [WIDTH:0]          w_shl;
    logic [WIDTH:0]          w_shr;
    logic signed [WIDTH:0]   w_sra;
    logic                    w_slt;
    logic [WIDTH-1:0]        w_res;
    logic                    w_c;
    logic                    w_v;
    logic                    w_is_alu;
    logic [3:0]              w_flags;
    logic                    w_alu_go;

    // Shifts carry one guard bit so the last bit shifted out lands in it.
    assign w_sh   = op_b[3:0];
    assign w_sum  = {1'b0, op_a} + {1'b0, op_b};
    assign w_diff = {1'b0, op_a} - {1'b0, op_b};
    assign w_shl  = {1'b0, op_a} << w_sh;
    assign w_shr  = {op_a, 1'b0} >> w_sh;
    assign w_sra  = $signed({op_a, 1'b0}) >>> w_sh;
    assign w_slt  = $signed(op_a) < $signed(op_b);

    // Single-cycle ALU result and carry/overflow; w_is_alu drops for NOP and MUL.
    always_comb begin
        w_res    = '0;
        w_c      = 1'b0;
        w_v      = 1'b0;
        w_is_alu = 1'b1;
        case (opcode)
            OP_ADD: begin
                w_res = w_sum[MSB:0];
                w_c   = w_sum[WIDTH];
                w_v   = (op_a[MSB] == op_b[MSB]) && (w_sum[MSB] != op_a[MSB]);
            end
            OP_SUB: begin
                w_res = w_diff[MSB:0];
                w_c   = w_diff[WIDTH];
                w_v   = (op_a[MSB] != op_b[MSB]) && (w_diff[MSB] != op_a[MSB]);
            end
            OP_AND: w_res = op_a & op_b;
            OP_OR:  w_res = op_a | op_b;
            OP_XOR: w_res = op_a ^ op_b;
            OP_NOT: w_res = ~op_a;
            OP_SHL: begin
                w_res = w_shl[MSB:0];
                w_c   = w_shl[WIDTH];
            end
            OP_SHR: begin
                w_res = w_shr[WIDTH:1];
                w_c   = w_shr[0];
            end
            OP_SRA: begin
                w_res = w_sra[WIDTH:1];
                w_c   = w_sra[0];
            end
            OP_MOV: w_res = op_b;
            OP_SLT: w_res = {{(WIDTH-1){1'b0}}, w_slt};
            default: w_is_alu = 1'b0;
        endcase
    end

    assign w_flags  = {w_res[MSB], (w_res == '0), w_c, w_v};
    assign w_alu_go = in_valid && in_ready && w_is_alu;

`ifdef ALU_MUL_EN
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_WB
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [CW-1:0]        r_cnt;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [AW-1:0]        r_mul_rd;
    logic [2*WIDTH-1:0]   w_acc_next;
    logic                 w_mul_go;
    logic                 w_mul_last;

    assign w_mul_go   = in_valid && in_ready && (opcode == OP_MUL);
    assign w_mul_last = (r_state == S_MUL) && (r_cnt == CNT_LAST);
    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state: accept MUL, iterate WIDTH times, one writeback cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_mul_go) w_next = S_MUL;
            S_MUL:   if (w_mul_last) w_next = S_WB;
            S_WB:    w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Outputs: only IDLE accepts new work.
    always_comb begin
        in_ready = (r_state == S_IDLE);
    end

    // Shift-add datapath on private operand copies; one partial product per clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_mul_rd <= '0;
        end else if (w_mul_go) begin
            r_acc    <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, op_a};
            r_mplier <= op_b;
            r_cnt    <= '0;
            r_mul_rd <= rd;
        end else if (r_state == S_MUL) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CW'(1);
        end
    end
`else
    assign in_ready = 1'b1;
`endif

    // Writeback register: strobe is one cycle; address/data move only on a real write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wb_write <= 1'b0;
            r_wb_ra    <= '0;
            r_wb_data  <= '0;
            r_flags    <= '0;
        end else begin
            r_wb_write <= 1'b0;
            if (w_alu_go) begin
                r_flags <= w_flags;
                if (rd != '0) begin
                    r_wb_write <= 1'b1;
                    r_wb_ra    <= rd;
                    r_wb_data  <= w_res;
                end
            end
`ifdef ALU_MUL_EN
            if (w_mul_last) begin
                r_flags <= {w_acc_next[MSB],
                            (w_acc_next[MSB:0] == '0),
                            (w_acc_next[2*WIDTH-1:WIDTH] != '0),
                            1'b0};
                if (r_mul_rd != '0) begin
                    r_wb_write <= 1'b1;
                    r_wb_ra    <= r_mul_rd;
                    r_wb_data  <= w_acc_next[MSB:0];
                end
            end
`endif
        end
    end

    assign wb_write = r_wb_write;
    assign wb_ra    = r_wb_ra;
    assign wb_data  = r_wb_data;
    assign flags    = r_flags;

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: randomized scoreboard bench for alu_exec_unit.
// Build with ALU_MUL_EN defined to exercise the multiplier path.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  opcode = 4'd0;
    logic [3:0]  rd = 4'd0;
    logic [15:0] op_a = 16'd0;
    logic [15:0] op_b = 16'd0;
    logic        wb_write;
    logic [3:0]  wb_ra;
    logic [15:0] wb_data;
    logic [3:0]  flags;

`ifdef ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    alu_exec_unit #(.WIDTH(16), .AW(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .rd(rd), .op_a(op_a), .op_b(op_b),
        .wb_write(wb_write), .wb_ra(wb_ra), .wb_data(wb_data), .flags(flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        bit          w;
        logic [3:0]  ra;
        logic [15:0] data;
        logic [3:0]  fl;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          n_pass = 0;
    int          n_tot = 0;
    int          mul_end = -1;
    bit          exp_ready = 1'b1;
    bit          mon_on = 1'b0;
    logic [3:0]  m_flags = 4'd0;
    logic [3:0]  m_ra = 4'd0;
    logic [15:0] m_data = 16'd0;
    exp_t        me;
    bit          mw;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [31:0] act, logic [31:0] want);
        n_tot++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, want, cyc);
    endtask

    // Reference behaviour from the opcode rules using integer arithmetic.
    function automatic void model(input logic [3:0] op, input logic [15:0] a,
                                  input logic [15:0] b, output logic [15:0] res,
                                  output logic [3:0] fl);
        int sa, sb_, sh, r;
        bit c, v;
        sa = int'($signed(a));
        sb_ = int'($signed(b));
        sh = int'(b[3:0]);
        r = 0; c = 1'b0; v = 1'b0;
        case (op)
            4'd0: begin
                r = int'(a) + int'(b);
                c = r > 65535;
                v = (sa + sb_ > 32767) || (sa + sb_ < -32768);
            end
            4'd1: begin
                r = int'(a) - int'(b);
                c = a < b;
                v = (sa - sb_ > 32767) || (sa - sb_ < -32768);
            end
            4'd2: r = int'(a & b);
            4'd3: r = int'(a | b);
            4'd4: r = int'(a ^ b);
            4'd5: r = int'(~a);
            4'd6: begin
                r = int'(a) << sh;
                c = ((r >> 16) & 1) != 0;
            end
            4'd7: begin
                r = int'(a) >> sh;
                c = (sh != 0) && (((int'(a) >> (sh - 1)) & 1) != 0);
            end
            4'd8: begin
                r = sa >>> sh;
                c = (sh != 0) && (((sa >>> (sh - 1)) & 1) != 0);
            end
            4'd9: r = int'(b);
            4'd10: r = (sa < sb_) ? 1 : 0;
            default: r = 0;
        endcase
        res = r[15:0];
        fl = {res[15], res == 16'h0, c, v};
    endfunction

    // Called at posedge+1; applies one cycle of inputs and records expectations.
    task automatic drive(bit v, logic [3:0] op, logic [3:0] r,
                         logic [15:0] a, logic [15:0] b);
        exp_t e;
        logic [15:0] res;
        logic [3:0] fl;
        longint p;
        chk("in_ready", 32'(in_ready), 32'(exp_ready));
        in_valid = v; opcode = op; rd = r; op_a = a; op_b = b;
        if (v && exp_ready) begin
            if (MUL_EN && op == 4'd11) begin
                p = longint'(a) * longint'(b);
                e.due = cyc + 17; e.w = (r != 4'd0); e.ra = r;
                e.data = p[15:0];
                e.fl = {p[15], p[15:0] == 16'h0, p[31:16] != 16'h0, 1'b0};
                sb.push_back(e);
                mul_end = cyc + 17;
            end else if (op <= 4'd10) begin
                model(op, a, b, res, fl);
                e.due = cyc + 1; e.w = (r != 4'd0); e.ra = r;
                e.data = res; e.fl = fl;
                sb.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        exp_ready = (cyc > mul_end);
    endtask

    task automatic reset_mid();
        in_valid = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        sb.delete();
        m_flags = 4'd0; m_ra = 4'd0; m_data = 16'd0;
        mul_end = -1; exp_ready = 1'b1;
        chk("rst_wb_write", 32'(wb_write), 32'd0);
        chk("rst_wb_ra", 32'(wb_ra), 32'd0);
        chk("rst_wb_data", 32'(wb_data), 32'd0);
        chk("rst_flags", 32'(flags), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 7))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h8000;
            3: return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    // Monitor: pops the entry due this cycle and compares all writeback outputs.
    always @(negedge clk) begin
        if (mon_on && !rst) begin
            mw = 1'b0;
            while (sb.size() > 0 && sb[0].due < cyc) begin
                chk("sb_late", 32'(cyc), 32'(sb[0].due));
                void'(sb.pop_front());
            end
            if (sb.size() > 0 && sb[0].due == cyc) begin
                me = sb.pop_front();
                mw = me.w;
                m_flags = me.fl;
                if (me.w) begin
                    m_ra = me.ra;
                    m_data = me.data;
                end
            end
            chk("wb_write", 32'(wb_write), 32'(mw));
            chk("flags", 32'(flags), 32'(m_flags));
            chk("wb_ra", 32'(wb_ra), 32'(m_ra));
            chk("wb_data", 32'(wb_data), 32'(m_data));
        end
    end

    initial begin
        #1;
        rst = 1'b1;
        #2;
        chk("init_wb_write", 32'(wb_write), 32'd0);
        chk("init_wb_ra", 32'(wb_ra), 32'd0);
        chk("init_wb_data", 32'(wb_data), 32'd0);
        chk("init_flags", 32'(flags), 32'd0);
        chk("init_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        mon_on = 1'b1;

        drive(1, 4'd0, 4'd3, 16'h7FFF, 16'h0001);
        chk("add_data", 32'(wb_data), 32'h8000);
        chk("add_flags", 32'(flags), 32'b1001);
        drive(1, 4'd1, 4'd1, 16'h0005, 16'h0005);
        chk("sub_flags", 32'(flags), 32'b0100);
        drive(1, 4'd6, 4'd2, 16'h8001, 16'h0001);
        chk("shl_data", 32'(wb_data), 32'h0002);
        chk("shl_flags", 32'(flags), 32'b0010);
        drive(1, 4'd10, 4'd4, 16'hFFFF, 16'h0001);
        chk("slt_data", 32'(wb_data), 32'h0001);
        chk("slt_write", 32'(wb_write), 32'd1);
        drive(1, 4'd4, 4'd0, 16'hFFFF, 16'hFFFF);
        chk("r0_write", 32'(wb_write), 32'd0);
        chk("r0_flags", 32'(flags), 32'b0100);
        chk("r0_data_hold", 32'(wb_data), 32'h0001);
        drive(1, 4'd12, 4'd5, 16'h1234, 16'h5678);
        chk("nop_flags", 32'(flags), 32'b0100);
        drive(0, 4'd0, 4'd0, 16'h0, 16'h0);
        reset_mid();

        if (MUL_EN) begin
            drive(1, 4'd11, 4'd5, 16'd300, 16'd300);
            for (int i = 0; i < 16; i++)
                drive(1'($urandom_range(0, 1)), 4'd0, 4'd7, pick(), pick());
            chk("mul_write", 32'(wb_write), 32'd1);
            chk("mul_data", 32'(wb_data), 32'h5F90);
            chk("mul_flags", 32'(flags), 32'b0010);
            drive(1, 4'd0, 4'd7, 16'h1, 16'h1);
            drive(0, 4'd0, 4'd0, 16'h0, 16'h0);
            drive(1, 4'd11, 4'd6, 16'h1234, 16'h5678);
            for (int i = 0; i < 8; i++)
                drive(0, 4'd0, 4'd0, 16'h0, 16'h0);
            reset_mid();
            for (int i = 0; i < 20; i++)
                drive(0, 4'd0, 4'd0, 16'h0, 16'h0);
        end else begin
            drive(1, 4'd0, 4'd9, 16'h0001, 16'h8000);
            drive(1, 4'd11, 4'd5, 16'd300, 16'd300);
            chk("op11_write", 32'(wb_write), 32'd0);
            chk("op11_flags", 32'(flags), 32'b1000);
            drive(0, 4'd0, 4'd0, 16'h0, 16'h0);
        end

        for (int i = 0; i < 400; i++)
            drive(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), pick(), pick());
        for (int i = 0; i < 20; i++)
            drive(0, 4'd0, 4'd0, 16'h0, 16'h0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
